// File: rtl/rename_map_if.sv
// ---------------------------------------------------------------------------
// rename_map_if -- signal bundle for the register-rename map.
//
// Handshake: a rename transfers on a cycle where ren_valid_i and ren_ready_o
// are both high (fire). The lookup results on prs*/prd/old_prd are
// combinational and valid in that same cycle. The producer may hold or change
// ren_valid_i freely. ren_ready_o never depends on ren_valid_i.
// Writeback, commit and flush are single-cycle strobes with no back-pressure.
//
// Ports (direction seen from the rename_map, i.e. the slave modport):
//   ren_valid_i / ren_ready_o      rename handshake
//   rs1/rs2/rd_addr_i, rd_wen_i    architectural operands of the instruction
//   prs1/prs2_addr_o, *_ready_o    physical sources and their availability
//   prd_addr_o, old_prd_addr_o     new destination and previous mapping of rd
//   wb_en_i, wb_preg_i             writeback, clears the busy bit
//   commit_*                       in-order retirement
//   flush_i                        squash all uncommitted renames
//   fl_count_o                     free-list occupancy
// ---------------------------------------------------------------------------
interface rename_map_if #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
);
    localparam int AW = $clog2(ARCH_REGS);
    localparam int PW = $clog2(PHYS_REGS);

    logic          ren_valid_i;
    logic          ren_ready_o;
    logic [AW-1:0] rs1_addr_i;
    logic [AW-1:0] rs2_addr_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_wen_i;
    logic [PW-1:0] prs1_addr_o;
    logic [PW-1:0] prs2_addr_o;
    logic          prs1_ready_o;
    logic          prs2_ready_o;
    logic [PW-1:0] prd_addr_o;
    logic [PW-1:0] old_prd_addr_o;
    logic          wb_en_i;
    logic [PW-1:0] wb_preg_i;
    logic          commit_en_i;
    logic          commit_rd_wen_i;
    logic [AW-1:0] commit_rd_addr_i;
    logic [PW-1:0] commit_prd_i;
    logic [PW-1:0] commit_old_prd_i;
    logic          flush_i;
    logic [PW:0]   fl_count_o;

    modport slave (
        input  ren_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, rd_wen_i,
        input  wb_en_i, wb_preg_i,
        input  commit_en_i, commit_rd_wen_i, commit_rd_addr_i, commit_prd_i, commit_old_prd_i,
        input  flush_i,
        output ren_ready_o, prs1_addr_o, prs2_addr_o, prs1_ready_o, prs2_ready_o,
        output prd_addr_o, old_prd_addr_o, fl_count_o
    );

    modport master (
        output ren_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, rd_wen_i,
        output wb_en_i, wb_preg_i,
        output commit_en_i, commit_rd_wen_i, commit_rd_addr_i, commit_prd_i, commit_old_prd_i,
        output flush_i,
        input  ren_ready_o, prs1_addr_o, prs2_addr_o, prs1_ready_o, prs2_ready_o,
        input  prd_addr_o, old_prd_addr_o, fl_count_o
    );
endinterface

// File: rtl/rename_map.sv
// ---------------------------------------------------------------------------
// rename_map -- register alias table with free list and busy table.
//
// Holds a speculative RAT (used for lookup and updated at rename), a committed
// RAT (updated at retirement, restored into the speculative RAT on flush), a
// busy bit per physical register, and a circular free list. The free list has
// a speculative head (advanced at rename), a commit head (advanced at
// retirement) and a tail (where retired old mappings are returned). A flush
// rewinds the speculative head to the commit head, which hands back every
// physical register allocated since the last retirement.
//
// Ports:
//   clk_i    clock, rising edge
//   reset_i  asynchronous active-high reset
//   bus      rename_map_if.slave (see interface header for signal list)
// ---------------------------------------------------------------------------
module rename_map #(
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    rename_map_if.slave bus
);
    localparam int AW       = $clog2(ARCH_REGS);
    localparam int PW       = $clog2(PHYS_REGS);
    localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
    localparam int FLW      = $clog2(FL_DEPTH);
    localparam int PTRW     = FLW + 1;   // index plus wrap bit

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PW-1:0]        spec_rat_q [ARCH_REGS];
    logic [PW-1:0]        spec_rat_d [ARCH_REGS];
    logic [PW-1:0]        com_rat_q  [ARCH_REGS];
    logic [PW-1:0]        com_rat_d  [ARCH_REGS];
    logic [PW-1:0]        fl_q       [FL_DEPTH];
    logic [PW-1:0]        fl_d       [FL_DEPTH];
    logic [PHYS_REGS-1:0] busy_q, busy_d;
    logic [PTRW-1:0]      spec_head_q, spec_head_d;
    logic [PTRW-1:0]      com_head_q,  com_head_d;
    logic [PTRW-1:0]      tail_q,      tail_d;

    // ------------------------------------------------------------------
    // Combinational lookup / handshake
    // ------------------------------------------------------------------
    logic [PTRW-1:0] fl_count_w;
    logic            ren_ready_w;
    logic            fire_w;
    logic            alloc_w;
    logic            commit_w;
    logic            wb_w;
    logic [PW-1:0]   prd_w;
    logic [PW-1:0]   prs1_w;
    logic [PW-1:0]   prs2_w;

    // Pointers carry a wrap bit, so the plain difference is the occupancy
    // and distinguishes full (FL_DEPTH) from empty (0).
    assign fl_count_w = tail_q - spec_head_q;
    assign bus.fl_count_o = {{(PW - FLW){1'b0}}, fl_count_w};

    // Readiness only looks at the registered occupancy: a commit pushing an
    // entry this cycle does not make an empty list ready until next cycle.
    assign ren_ready_w     = (fl_count_w != '0) && !bus.flush_i;
    assign bus.ren_ready_o = ren_ready_w;

    assign fire_w   = bus.ren_valid_i && ren_ready_w;
    assign alloc_w  = fire_w && bus.rd_wen_i && (bus.rd_addr_i != '0);
    assign commit_w = bus.commit_en_i && bus.commit_rd_wen_i && (bus.commit_rd_addr_i != '0);
    assign wb_w     = bus.wb_en_i && (bus.wb_preg_i != '0);

    assign prd_w              = alloc_w ? fl_q[spec_head_q[FLW-1:0]] : '0;
    assign bus.prd_addr_o     = prd_w;
    assign bus.old_prd_addr_o = (bus.rd_addr_i == '0) ? '0 : spec_rat_q[bus.rd_addr_i];

    assign prs1_w = (bus.rs1_addr_i == '0) ? '0 : spec_rat_q[bus.rs1_addr_i];
    assign prs2_w = (bus.rs2_addr_i == '0) ? '0 : spec_rat_q[bus.rs2_addr_i];
    assign bus.prs1_addr_o = prs1_w;
    assign bus.prs2_addr_o = prs2_w;

    // A writeback landing in the lookup cycle is forwarded into readiness.
    assign bus.prs1_ready_o = (bus.rs1_addr_i == '0) || !busy_q[prs1_w] ||
                              (bus.wb_en_i && (bus.wb_preg_i == prs1_w));
    assign bus.prs2_ready_o = (bus.rs2_addr_i == '0) || !busy_q[prs2_w] ||
                              (bus.wb_en_i && (bus.wb_preg_i == prs2_w));

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        spec_rat_d  = spec_rat_q;
        com_rat_d   = com_rat_q;
        fl_d        = fl_q;
        busy_d      = busy_q;
        spec_head_d = spec_head_q;
        com_head_d  = com_head_q;
        tail_d      = tail_q;

        // Retirement: the old mapping of rd becomes free again.
        if (commit_w) begin
            com_rat_d[bus.commit_rd_addr_i] = bus.commit_prd_i;
            fl_d[tail_q[FLW-1:0]]           = bus.commit_old_prd_i;
            tail_d                          = tail_q + 1'b1;
            com_head_d                      = com_head_q + 1'b1;
        end

        if (bus.flush_i) begin
            // Restore from the committed state including this cycle's commit.
            // Nothing survives a flush in flight, so no register is busy.
            spec_rat_d  = com_rat_d;
            spec_head_d = com_head_d;
            busy_d      = '0;
        end else begin
            if (wb_w) begin
                busy_d[bus.wb_preg_i] = 1'b0;
            end
            // Applied after writeback so a same-preg collision leaves it busy.
            if (alloc_w) begin
                spec_rat_d[bus.rd_addr_i] = prd_w;
                busy_d[prd_w]             = 1'b1;
                spec_head_d               = spec_head_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                spec_rat_q[i] <= PW'(i);
                com_rat_q[i]  <= PW'(i);
            end
            for (int j = 0; j < FL_DEPTH; j++) begin
                fl_q[j] <= PW'(ARCH_REGS + j);
            end
            busy_q      <= '0;
            spec_head_q <= '0;
            com_head_q  <= '0;
            tail_q      <= PTRW'(FL_DEPTH);   // full list: wrap bit set
        end else begin
            spec_rat_q  <= spec_rat_d;
            com_rat_q   <= com_rat_d;
            fl_q        <= fl_d;
            busy_q      <= busy_d;
            spec_head_q <= spec_head_d;
            com_head_q  <= com_head_d;
            tail_q      <= tail_d;
        end
    end

endmodule
